// File: rtl/ledseq_pkg.sv
// Shared definitions for the LED pattern sequencer: register map,
// CTRL/STATUS bit positions, FSM state encoding and a small clamp helper.
package ledseq_pkg;

  // Avalon register addresses
  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_PERIOD = 3'd1;
  localparam logic [2:0] ADDR_LENGTH = 3'd2;
  localparam logic [2:0] ADDR_DIRECT = 3'd3;
  localparam logic [2:0] ADDR_PADDR  = 3'd4;
  localparam logic [2:0] ADDR_PDATA  = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  // CTRL bit positions (busy is read-only)
  localparam int CTRL_RUN    = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_BUSY   = 3;

  // STATUS bit positions
  localparam int STATUS_DONE    = 0;
  localparam int STATUS_IDX_LSB = 8;

  // Sequencer state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Saturate a bus value to an upper limit (used for the LENGTH register)
  function automatic logic [31:0] clamp_to(input logic [31:0] value, input int unsigned limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/led_pattern_ram.sv
// Pattern table: one synchronous write port driven by the PDATA register,
// one asynchronous read port addressed by the current step index.
module led_pattern_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Table write; contents are not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read so an entry rewritten mid-run shows on its next display
  assign rdata = mem[raddr];

endmodule

// File: rtl/led_pattern_sequencer.sv
// Avalon-MM LED pattern sequencer: register file, step counter and
// IDLE/RUN/DONE sequencer driving a registered LED output.
module led_pattern_sequencer
  import ledseq_pkg::*;
#(
  parameter int LED_W = 10,
  parameter int DEPTH = 16,
  parameter int PER_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] out_port,
  output logic             irq
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  // Bus decode
  logic wr;
  logic ctrl_wr;
  logic status_wr;
  logic pdata_wr;

  // Register file
  logic             run_reg;
  logic             loop_reg;
  logic             irq_en_reg;
  logic [PER_W-1:0] period_reg;
  logic [LW-1:0]    length_reg;
  logic [LED_W-1:0] direct_reg;
  logic [IW-1:0]    paddr_reg;
  logic             done_reg;

  // Sequencer
  state_t           state_reg;
  state_t           state_next;
  logic [IW-1:0]    idx_reg;
  logic [IW-1:0]    idx_next;
  logic [PER_W-1:0] cnt_reg;
  logic [PER_W-1:0] cnt_next;
  logic             set_done;
  logic             clr_run;

  logic [LED_W-1:0] ram_rdata;
  logic [PER_W-1:0] period_eff;
  logic             step_end;
  logic             last_step;

  assign wr        = chipselect & ~write_n;
  assign ctrl_wr   = wr && (address == ADDR_CTRL);
  assign status_wr = wr && (address == ADDR_STATUS);
  assign pdata_wr  = wr && (address == ADDR_PDATA);

  // A zero period behaves like one clock per step
  assign period_eff = (period_reg == '0) ? PER_W'(1) : period_reg;
  // >= rather than == so a PERIOD shrunk below the running count still ends the step
  assign step_end   = cnt_reg >= (period_eff - PER_W'(1));
  // Same reasoning for LENGTH shrinking mid-run
  assign last_step  = ({1'b0, idx_reg} + LW'(1)) >= length_reg;

  led_pattern_ram #(
    .DEPTH (DEPTH),
    .WIDTH (LED_W)
  ) u_ram (
    .clk   (clk),
    .we    (pdata_wr),
    .waddr (paddr_reg),
    .wdata (writedata[LED_W-1:0]),
    .raddr (idx_reg),
    .rdata (ram_rdata)
  );

  // Next-state logic: a CTRL write (restart or abort) always beats a step end
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    set_done   = 1'b0;
    clr_run    = 1'b0;
    if (ctrl_wr) begin
      idx_next = '0;
      cnt_next = '0;
      if (!writedata[CTRL_RUN]) begin
        state_next = ST_IDLE;
      end else if (length_reg == '0) begin
        state_next = ST_DONE;
        set_done   = 1'b1;
        clr_run    = 1'b1;
      end else begin
        state_next = ST_RUN;
      end
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (step_end) begin
            cnt_next = '0;
            if (last_step) begin
              if (loop_reg) begin
                idx_next = '0;
              end else begin
                state_next = ST_DONE;
                set_done   = 1'b1;
                clr_run    = 1'b1;
              end
            end else begin
              idx_next = idx_reg + IW'(1);
            end
          end else begin
            cnt_next = cnt_reg + PER_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sequencer state, step index and step counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Software-visible registers; sequencer side effects override bus writes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_reg    <= 1'b0;
      loop_reg   <= 1'b0;
      irq_en_reg <= 1'b0;
      period_reg <= '0;
      length_reg <= '0;
      direct_reg <= '0;
      paddr_reg  <= '0;
      done_reg   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        run_reg    <= writedata[CTRL_RUN];
        loop_reg   <= writedata[CTRL_LOOP];
        irq_en_reg <= writedata[CTRL_IRQ_EN];
      end
      if (clr_run) begin
        run_reg <= 1'b0;
      end
      if (wr && (address == ADDR_PERIOD)) begin
        period_reg <= writedata[PER_W-1:0];
      end
      if (wr && (address == ADDR_LENGTH)) begin
        length_reg <= LW'(clamp_to(writedata, DEPTH));
      end
      if (wr && (address == ADDR_DIRECT)) begin
        direct_reg <= writedata[LED_W-1:0];
      end
      if (wr && (address == ADDR_PADDR)) begin
        paddr_reg <= writedata[IW-1:0];
      end else if (pdata_wr) begin
        paddr_reg <= paddr_reg + IW'(1);
      end
      if (set_done) begin
        done_reg <= 1'b1;
      end else if (status_wr) begin
        done_reg <= 1'b0;
      end
    end
  end

  // LED output lags state/index by one clock; DONE freezes the last pattern
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_port <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: out_port <= direct_reg;
        ST_RUN:  out_port <= ram_rdata;
        default: out_port <= out_port;
      endcase
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_RUN]    = run_reg;
        readdata[CTRL_LOOP]   = loop_reg;
        readdata[CTRL_IRQ_EN] = irq_en_reg;
        readdata[CTRL_BUSY]   = (state_reg == ST_RUN);
      end
      ADDR_PERIOD: readdata[PER_W-1:0] = period_reg;
      ADDR_LENGTH: readdata[LW-1:0]    = length_reg;
      ADDR_DIRECT: readdata[LED_W-1:0] = direct_reg;
      ADDR_PADDR:  readdata[IW-1:0]    = paddr_reg;
      ADDR_STATUS: begin
        readdata[STATUS_DONE]              = done_reg;
        readdata[STATUS_IDX_LSB +: IW]     = idx_reg;
      end
      default: begin
      end
    endcase
  end

  assign irq = done_reg & irq_en_reg;

endmodule
